// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetch PC, in-order imem requests, prefetch FIFO, redirect flush.
// Define FETCH_BYPASS_EN to let a response reach decode in its arrival cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(2 * DEPTH + 1);
    localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] out_q, out_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [31:0]   fifo_pc_q [DEPTH];
    logic [31:0]   fifo_pc_d [DEPTH];
    logic [31:0]   fifo_word_q [DEPTH];
    logic [31:0]   fifo_word_d [DEPTH];

    logic [31:0] tgt_pc;
    logic [CW:0] credit;
    logic        fifo_nonempty;
    logic        rsp_drop;
    logic        rsp_take;
    logic        bypass_hit;
    logic        issue;
    logic        pop;
    logic        push;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == LAST) ? '0 : p + IW'(1);
    endfunction

    assign tgt_pc        = redirect_pc & 32'hFFFF_FFFC;
    assign credit        = {1'b0, count_q} + {1'b0, out_q};
    assign fifo_nonempty = (count_q != '0);

    assign imem_req_valid = rst_n && !redirect && (credit < {1'b0, DEPTH_C});
    assign imem_req_addr  = fetch_pc_q;

    // A flushed request's response only pays down the drop debt.
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_take = imem_rsp_valid && (drop_q == '0) && !redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = rsp_take && !fifo_nonempty;
`else
    assign bypass_hit = 1'b0;
`endif

    assign issue = imem_req_valid && imem_req_ready;
    assign pop   = fifo_nonempty && instr_ready;
    assign push  = rsp_take && !(bypass_hit && instr_ready);

    always_comb begin
        instr_valid = fifo_nonempty || bypass_hit;
        instr       = '0;
        instr_pc    = '0;
        if (fifo_nonempty) begin
            instr    = fifo_word_q[head_q];
            instr_pc = fifo_pc_q[head_q];
        end else if (bypass_hit) begin
            instr    = imem_rsp_data;
            instr_pc = rsp_pc_q;
        end
        instr_pc_plus4 = instr_valid ? instr_pc + 32'd4 : '0;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        drop_d      = drop_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_word_d = fifo_word_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        out_d       = out_q + CW'(issue) - CW'(rsp_take);
        if (push) begin
            fifo_pc_d[tail_q]   = rsp_pc_q;
            fifo_word_d[tail_q] = imem_rsp_data;
            tail_d              = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        if (rsp_take) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (rsp_drop) begin
            drop_d = drop_q - DW'(1);
        end
        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        // Everything still owed by memory becomes debt; a response now settles one.
        if (redirect) begin
            fetch_pc_d = tgt_pc;
            rsp_pc_d   = tgt_pc;
            count_d    = '0;
            out_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            drop_d     = drop_q + DW'(out_q) - DW'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            rsp_pc_q   <= RESET_PC & 32'hFFFF_FFFC;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_word_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            count_q     <= count_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_word_q <= fifo_word_d;
        end
    end
endmodule
